tlk2711_tx_cmd_mc: RTL and testbench
====================================

// Module: tlk2711_tx_cmd_mc
// PURPOSE
//  Multi-channel successor of the TLK2711 TX command generator.
//  Per channel: splits a transfer into i_body_num body reads plus one optional tail read, all 8B-aligned.
//  Arbitrates channels round-robin onto one DMA read-command req/ack port.
//  Tracks one outstanding command per channel; each command retires on a channel-tagged DMA last.
// PARAMETERS
//  NUM_CH      4   number of TX channels (1..16)
//  ADDR_WIDTH  32  DMA byte address width
//  DLEN_WIDTH  16  command byte-length width
//  CH_W        $clog2(NUM_CH), min 1 (localparam)
// PORTS
//  clk               in   1                 clock
//  rst               in   1                 reset (sync, active-high)
//  i_soft_rst        in   NUM_CH            per-channel abort pulse
//  i_tx_start        in   NUM_CH            per-channel start pulse
//  i_tx_base_addr    in   NUM_CH*ADDR_WIDTH per-channel start address (ch0 in LSBs)
//  i_tx_packet_body  in   NUM_CH*16         body length, bytes
//  i_tx_packet_tail  in   NUM_CH*16         tail length, bytes; 0 = no tail
//  i_tx_body_num     in   NUM_CH*16         number of body reads
//  o_rd_cmd_req      out  1                 command valid
//  i_rd_cmd_ack      in   1                 command accepted
//  o_rd_cmd_data     out  CH_W+ADDR_WIDTH+DLEN_WIDTH  {ch, addr, len}
//  i_dma_rd_last     in   1                 DMA read-data last beat
//  i_dma_rd_ch       in   CH_W              channel owning the last beat
//  o_ch_busy         out  NUM_CH            channel not IDLE
//  o_ch_done         out  NUM_CH            1-cycle pulse: final read retired
//  o_err             out  1                 1-cycle pulse: protocol error
// BEHAVIOUR
//  - Reset: all outputs 0; all channels IDLE; RR pointer = 0.
//  - Per-channel FSM:
//      IDLE --start--> REQ
//      REQ --granted & ack--> WAIT
//      WAIT --last(ch)--> REQ if more reads remain, else IDLE with o_ch_done pulse
//      DRAIN --last(ch)--> IDLE, no done pulse
//  - Start, cycle T: latches config, frame_cnt=0, addr=base; channel enters REQ at T+1.
//    Start while busy or with body_len==0 is ignored and pulses o_err.
//  - Lengths are rounded up to a multiple of 8 ({len[15:3]+|len[2:0], 3'b0}), truncated to DLEN_WIDTH.
//    Address advances by the aligned body length, modulo 2^ADDR_WIDTH.
//  - frame_cnt < body_num issues a body read; frame_cnt == body_num issues the tail read if tail != 0.
//    body_num==0 with tail!=0 gives one tail-only read. body_num==0 with tail==0 goes straight to
//    IDLE at T+1 with o_ch_done pulsed.
//  - Arbiter: registered. When o_rd_cmd_req is low, picks the first REQ channel at or after the
//    RR pointer and drives req+data on the next cycle.
//    req/data stay stable until ack. On ack, req drops next cycle; RR pointer = granted+1.
//    Minimum 1 idle cycle between commands; start-to-req latency is 2 cycles with no contention.
//  - last for a channel not in WAIT/DRAIN: ignored, o_err pulses.
//    last and ack in the same cycle (any channels) are both honoured.
//  - soft_rst(ch):
//      * IDLE/REQ -> IDLE, and pending req withdrawn unless already acked this cycle.
//      * WAIT -> DRAIN.
//      * soft_rst together with start: soft_rst wins.
//  - rst mid-operation aborts everything; late DMA lasts are then flagged via o_err.
// CONFIGURATION
//  TLK2711_TX_CMD_WRAP_EN:
//   * Defined: adds input i_ring_bytes [ADDR_WIDTH] (shared, multiple of 8, nonzero).
//     Address is kept as an offset from base; when offset+len >= i_ring_bytes the offset wraps
//     to (offset+len-i_ring_bytes).
//     A read straddling the ring end is still issued whole; software sizes the ring in body multiples.
//   * Undefined: no port, linear addressing.
// STRUCTURE
//  - Package tlk2711_pkg: channel FSM state enum (IDLE,REQ,WAIT,DRAIN), ALIGN_BYTES=8,
//    align8 length function.
//  - Sub-module tlk2711_tx_cmd_ch: one per channel (generate), holding the FSM, counter and address.
//  - Top: round-robin arbiter, command register, error OR.
// TESTING
//  1. NUM_CH=1, base=0x1000, body=870, tail=100, num=2 ->
//     cmds {0x1000,872},{0x1368,872},{0x16D0,104}; done after 3rd last.
//  2. Start ch0..3 in the same cycle -> grants ch0,1,2,3 in order; ack held off 5 cycles keeps
//     req/data stable.
//  3. tail=0, num=1 -> exactly one cmd; done pulse; no tail request.
//  4. soft_rst ch1 in WAIT -> no further ch1 cmds; ch1 last -> IDLE, no done, no o_err;
//     other channels unaffected.
//  5. Stray last on idle ch2; start on busy ch0 -> o_err pulses each, state unchanged.
//  6. WRAP_EN, ring=0x800, body=0x400, num=3 -> offsets 0x000,0x400,0x000 (+base).

Source files
------------

// File: rtl/tlk2711_pkg.sv
// Shared definitions for the multi-channel TLK2711 TX command generator.
// Contents:
//   ch_state_e  - per-channel FSM state (IDLE, REQ, WAIT, DRAIN)
//   ALIGN_BYTES - DMA alignment granule in bytes
//   align8()    - rounds a 16-bit byte length up to the next multiple of 8
package tlk2711_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } ch_state_e;

  localparam int ALIGN_BYTES = 8;

  // The result is 17 bits wide because 0xFFF9..0xFFFF round up to 0x10000;
  // callers truncate to their command length width.
  function automatic logic [16:0] align8(input logic [15:0] len);
    logic [13:0] granules;
    granules = {1'b0, len[15:3]} + {13'd0, |len[2:0]};
    return {granules, 3'b000};
  endfunction

endpackage

// File: rtl/tlk2711_tx_cmd_ch.sv
// One TX channel of the command generator: holds the channel FSM, the
// read counter and the running address, and presents the command it wants
// issued while in REQ.
// Optional feature macro: TLK2711_TX_CMD_WRAP_EN (ring-buffer addressing).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   soft_rst            abort pulse for this channel
//   start               start pulse; latches the transfer configuration
//   base_addr           transfer start address
//   packet_body/tail    body / tail lengths in bytes (tail 0 = no tail)
//   body_num            number of body reads
//   ring_bytes          ring size (only with TLK2711_TX_CMD_WRAP_EN)
//   cmd_ack             this channel's command was accepted this cycle
//   dma_last            DMA last beat tagged with this channel
//   req                 channel is in REQ
//   cmd_addr, cmd_len   command the channel wants issued
//   busy                channel not IDLE
//   done                registered pulse: final read retired
//   err                 combinational: protocol error this cycle
module tlk2711_tx_cmd_ch
  import tlk2711_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DLEN_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  soft_rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           packet_body,
  input  logic [15:0]           packet_tail,
  input  logic [15:0]           body_num,
`ifdef TLK2711_TX_CMD_WRAP_EN
  input  logic [ADDR_WIDTH-1:0] ring_bytes,
`endif
  input  logic                  cmd_ack,
  input  logic                  dma_last,
  output logic                  req,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [DLEN_WIDTH-1:0] cmd_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int AW1 = ADDR_WIDTH + 1;

  ch_state_e             state_r;
  ch_state_e             state_nxt_s;
  logic                  load_s;
  logic                  advance_s;
  logic                  done_s;
  logic                  err_s;
  logic                  done_r;
  logic [16:0]           frame_cnt_r;
  logic [16:0]           frame_nxt_s;
  logic [15:0]           num_r;
  logic                  has_tail_r;
  logic [DLEN_WIDTH-1:0] body_len_r;
  logic [DLEN_WIDTH-1:0] tail_len_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] addr_nxt_s;
  logic                  is_body_s;
  logic                  more_s;

  // frame_cnt is one bit wider than body_num so the tail slot (== body_num)
  // and "past the tail" (body_num+1) never alias, even for body_num=0xFFFF.
  assign is_body_s   = (frame_cnt_r < {1'b0, num_r});
  assign frame_nxt_s = frame_cnt_r + 17'd1;
  assign more_s      = (frame_nxt_s < {1'b0, num_r}) |
                       ((frame_nxt_s == {1'b0, num_r}) & has_tail_r);

`ifdef TLK2711_TX_CMD_WRAP_EN
  // addr_r holds the offset from base; it wraps at the ring size.
  logic [ADDR_WIDTH-1:0] base_r;
  logic [AW1-1:0]        off_sum_s;

  assign off_sum_s  = {1'b0, addr_r} + AW1'(body_len_r);
  assign addr_nxt_s = (off_sum_s >= {1'b0, ring_bytes}) ?
                      ADDR_WIDTH'(off_sum_s - {1'b0, ring_bytes}) :
                      ADDR_WIDTH'(off_sum_s);
  assign cmd_addr   = base_r + addr_r;

  // Base address register for ring mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r <= {ADDR_WIDTH{1'b0}};
    end else if (load_s) begin
      base_r <= base_addr;
    end
  end
`else
  // addr_r holds the absolute address; it simply wraps modulo 2^ADDR_WIDTH.
  assign addr_nxt_s = addr_r + ADDR_WIDTH'(body_len_r);
  assign cmd_addr   = addr_r;
`endif

  assign cmd_len = is_body_s ? body_len_r : tail_len_r;
  assign req     = (state_r == REQ);
  assign busy    = (state_r != IDLE);
  assign done    = done_r;
  assign err     = err_s;

  // Channel state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode plus load/advance/done/error strobes.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    advance_s   = 1'b0;
    done_s      = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      IDLE: begin
        err_s = dma_last | (start & ~soft_rst & (packet_body == 16'd0));
        if (start && !soft_rst && (packet_body != 16'd0)) begin
          load_s = 1'b1;
          if ((body_num == 16'd0) && (packet_tail == 16'd0)) begin
            done_s      = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = REQ;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        err_s = dma_last | (start & ~soft_rst);
        // An accepted command is in flight even if aborted, so its last must be drained.
        if (cmd_ack) begin
          state_nxt_s = soft_rst ? DRAIN : WAIT;
        end else if (soft_rst) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        err_s = start & ~soft_rst;
        if (dma_last) begin
          advance_s = 1'b1;
          if (soft_rst) begin
            state_nxt_s = IDLE;
          end else if (more_s) begin
            state_nxt_s = REQ;
          end else begin
            state_nxt_s = IDLE;
            done_s      = 1'b1;
          end
        end else if (soft_rst) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DRAIN: begin
        err_s = start & ~soft_rst;
        if (dma_last) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Transfer configuration, read counter and address.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_r <= 17'd0;
      num_r       <= 16'd0;
      has_tail_r  <= 1'b0;
      body_len_r  <= {DLEN_WIDTH{1'b0}};
      tail_len_r  <= {DLEN_WIDTH{1'b0}};
      addr_r      <= {ADDR_WIDTH{1'b0}};
    end else if (load_s) begin
      frame_cnt_r <= 17'd0;
      num_r       <= body_num;
      has_tail_r  <= (packet_tail != 16'd0);
      body_len_r  <= DLEN_WIDTH'(align8(packet_body));
      tail_len_r  <= DLEN_WIDTH'(align8(packet_tail));
`ifdef TLK2711_TX_CMD_WRAP_EN
      addr_r      <= {ADDR_WIDTH{1'b0}};
`else
      addr_r      <= base_addr;
`endif
    end else if (advance_s) begin
      frame_cnt_r <= frame_nxt_s;
      addr_r      <= is_body_s ? addr_nxt_s : addr_r;
    end
  end

  // Done pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_r <= 1'b0;
    end else begin
      done_r <= done_s;
    end
  end

endmodule

// File: rtl/tlk2711_tx_cmd_mc.sv
// Multi-channel TLK2711 TX command generator. Each channel splits a transfer
// into body reads plus an optional tail read; a registered round-robin
// arbiter places channel commands onto a single DMA read-command port, and
// channel-tagged DMA last beats retire them.
// Optional feature macro: TLK2711_TX_CMD_WRAP_EN adds i_ring_bytes and
// ring-buffer addressing (offset from base wraps at the ring size).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_soft_rst        per-channel abort pulse
//   i_tx_start        per-channel start pulse
//   i_tx_base_addr    per-channel start address (ch0 in LSBs)
//   i_tx_packet_body  per-channel body length, bytes
//   i_tx_packet_tail  per-channel tail length, bytes (0 = no tail)
//   i_tx_body_num     per-channel number of body reads
//   i_ring_bytes      ring size, shared (only with TLK2711_TX_CMD_WRAP_EN)
//   o_rd_cmd_req      command valid, held until i_rd_cmd_ack
//   i_rd_cmd_ack      command accepted
//   o_rd_cmd_data     {ch, addr, len}
//   i_dma_rd_last     DMA read-data last beat
//   i_dma_rd_ch       channel owning the last beat
//   o_ch_busy         channel not IDLE
//   o_ch_done         pulse: channel's final read retired
//   o_err             pulse: protocol error
module tlk2711_tx_cmd_mc
  import tlk2711_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DLEN_WIDTH = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CMD_W      = CH_W + ADDR_WIDTH + DLEN_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            i_soft_rst,
  input  logic [NUM_CH-1:0]            i_tx_start,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] i_tx_base_addr,
  input  logic [NUM_CH*16-1:0]         i_tx_packet_body,
  input  logic [NUM_CH*16-1:0]         i_tx_packet_tail,
  input  logic [NUM_CH*16-1:0]         i_tx_body_num,
`ifdef TLK2711_TX_CMD_WRAP_EN
  input  logic [ADDR_WIDTH-1:0]        i_ring_bytes,
`endif
  output logic                         o_rd_cmd_req,
  input  logic                         i_rd_cmd_ack,
  output logic [CMD_W-1:0]             o_rd_cmd_data,
  input  logic                         i_dma_rd_last,
  input  logic [CH_W-1:0]              i_dma_rd_ch,
  output logic [NUM_CH-1:0]            o_ch_busy,
  output logic [NUM_CH-1:0]            o_ch_done,
  output logic                         o_err
);

  localparam int              CHW1     = CH_W + 1;
  localparam logic [CH_W:0]   NUM_CH_L = CHW1'(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  logic [NUM_CH-1:0]     ch_req_s;
  logic [NUM_CH-1:0]     ch_ack_s;
  logic [NUM_CH-1:0]     ch_last_s;
  logic [NUM_CH-1:0]     ch_err_s;
  logic [ADDR_WIDTH-1:0] ch_addr_s [NUM_CH];
  logic [DLEN_WIDTH-1:0] ch_len_s  [NUM_CH];

  logic                  rd_cmd_req_r;
  logic [CMD_W-1:0]      rd_cmd_data_r;
  logic [CH_W-1:0]       grant_ch_r;
  logic [CH_W-1:0]       rr_ptr_r;
  logic                  err_r;

  logic                  pick_vld_s;
  logic [CH_W-1:0]       pick_ch_s;
  logic [CH_W:0]         rr_sum_s;
  logic [CH_W-1:0]       rr_idx_s;
  logic [CH_W-1:0]       rr_next_s;
  logic                  bad_last_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_ack_s[g]  = rd_cmd_req_r & i_rd_cmd_ack & (grant_ch_r == CH_W'(g));
    assign ch_last_s[g] = i_dma_rd_last & (i_dma_rd_ch == CH_W'(g));

    tlk2711_tx_cmd_ch #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DLEN_WIDTH (DLEN_WIDTH)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .soft_rst    (i_soft_rst[g]),
      .start       (i_tx_start[g]),
      .base_addr   (i_tx_base_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .packet_body (i_tx_packet_body[g*16 +: 16]),
      .packet_tail (i_tx_packet_tail[g*16 +: 16]),
      .body_num    (i_tx_body_num[g*16 +: 16]),
`ifdef TLK2711_TX_CMD_WRAP_EN
      .ring_bytes  (i_ring_bytes),
`endif
      .cmd_ack     (ch_ack_s[g]),
      .dma_last    (ch_last_s[g]),
      .req         (ch_req_s[g]),
      .cmd_addr    (ch_addr_s[g]),
      .cmd_len     (ch_len_s[g]),
      .busy        (o_ch_busy[g]),
      .done        (o_ch_done[g]),
      .err         (ch_err_s[g])
    );
  end

  // A last tagged with a channel number that does not exist is an error too.
  assign bad_last_s = i_dma_rd_last & ({1'b0, i_dma_rd_ch} >= NUM_CH_L);
  assign rr_next_s  = (grant_ch_r == LAST_CH) ? {CH_W{1'b0}} : (grant_ch_r + CH_W'(1));

  // Round-robin search: first requesting channel at or after the pointer.
  // Channels being aborted this cycle are skipped so no dead command is issued.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_ch_s  = {CH_W{1'b0}};
    rr_sum_s   = {(CH_W+1){1'b0}};
    rr_idx_s   = {CH_W{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      rr_sum_s = {1'b0, rr_ptr_r} + CHW1'(k);
      rr_idx_s = (rr_sum_s >= NUM_CH_L) ? CH_W'(rr_sum_s - NUM_CH_L) : CH_W'(rr_sum_s);
      if (!pick_vld_s && ch_req_s[rr_idx_s] && !i_soft_rst[rr_idx_s]) begin
        pick_vld_s = 1'b1;
        pick_ch_s  = rr_idx_s;
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // Command register: grant when idle, hold until ack, withdraw on abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cmd_req_r  <= 1'b0;
      rd_cmd_data_r <= {CMD_W{1'b0}};
      grant_ch_r    <= {CH_W{1'b0}};
      rr_ptr_r      <= {CH_W{1'b0}};
    end else if (rd_cmd_req_r) begin
      if (i_rd_cmd_ack) begin
        rd_cmd_req_r <= 1'b0;
        rr_ptr_r     <= rr_next_s;
      end else if (i_soft_rst[grant_ch_r]) begin
        rd_cmd_req_r <= 1'b0;
      end
    end else if (pick_vld_s) begin
      rd_cmd_req_r  <= 1'b1;
      grant_ch_r    <= pick_ch_s;
      rd_cmd_data_r <= {pick_ch_s, ch_addr_s[pick_ch_s], ch_len_s[pick_ch_s]};
    end
  end

  // Error pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= (|ch_err_s) | bad_last_s;
    end
  end

  assign o_rd_cmd_req  = rd_cmd_req_r;
  assign o_rd_cmd_data = rd_cmd_data_r;
  assign o_err         = err_r;

endmodule

// File: tb/tb_tlk2711_tx_cmd_mc.sv
// Self-checking bench for tlk2711_tx_cmd_mc (NUM_CH=4, 32-bit address,
// 16-bit length). Expected commands are pushed to a scoreboard queue when a
// transfer is started and popped as the DUT presents commands.
module tb_tlk2711_tx_cmd_mc;

  localparam int NUM_CH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   soft_rst;
  logic [3:0]   start;
  logic [127:0] base;
  logic [63:0]  body;
  logic [63:0]  tail;
  logic [63:0]  num;
  logic         req;
  logic         ack;
  logic [49:0]  data;
  logic         last;
  logic [1:0]   last_ch;
  logic [3:0]   busy;
  logic [3:0]   done;
  logic         err;
`ifdef TLK2711_TX_CMD_WRAP_EN
  logic [31:0]  ring;
`endif

  always #5 clk = ~clk;

  tlk2711_tx_cmd_mc #(.NUM_CH(NUM_CH), .ADDR_WIDTH(32), .DLEN_WIDTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_soft_rst       (soft_rst),
    .i_tx_start       (start),
    .i_tx_base_addr   (base),
    .i_tx_packet_body (body),
    .i_tx_packet_tail (tail),
    .i_tx_body_num    (num),
`ifdef TLK2711_TX_CMD_WRAP_EN
    .i_ring_bytes     (ring),
`endif
    .o_rd_cmd_req     (req),
    .i_rd_cmd_ack     (ack),
    .o_rd_cmd_data    (data),
    .i_dma_rd_last    (last),
    .i_dma_rd_ch      (last_ch),
    .o_ch_busy        (busy),
    .o_ch_done        (done),
    .o_err            (err)
  );

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic [15:0] len;
  } cmd_t;

  typedef struct {
    int          ch;
    logic [31:0] base;
    logic [15:0] body;
    logic [15:0] tail;
    logic [15:0] num;
    int          exp_n;
    logic [31:0] exp_last_addr;
    logic [15:0] exp_last_len;
  } vec_t;

  cmd_t exp_q[$];
  vec_t vecs[6];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cfg(input int ch, input logic [31:0] b, input logic [15:0] bl,
                     input logic [15:0] tl, input logic [15:0] n);
    base[ch*32 +: 32] = b;
    body[ch*16 +: 16] = bl;
    tail[ch*16 +: 16] = tl;
    num[ch*16 +: 16]  = n;
  endtask

  task automatic push_cmd(input int ch, input logic [31:0] a, input logic [15:0] l);
    cmd_t c;
    c.ch = ch; c.addr = a; c.len = l;
    exp_q.push_back(c);
  endtask

  // Reference model: body reads then optional tail, lengths rounded up to 8.
  task automatic push_xfer(input int ch, input logic [31:0] b, input logic [15:0] bl,
                           input logic [15:0] tl, input logic [15:0] n);
    logic [31:0] a;
    logic [15:0] blen;
    logic [15:0] tlen;
    blen = 16'(((32'(bl) + 32'd7) / 32'd8) * 32'd8);
    tlen = 16'(((32'(tl) + 32'd7) / 32'd8) * 32'd8);
    a = b;
    for (int i = 0; i < int'(n); i++) begin
      push_cmd(ch, a, blen);
      a = a + 32'(blen);
    end
    if (tl != 16'd0) push_cmd(ch, a, tlen);
  endtask

  // Called at a negedge; start is seen by the next posedge.
  task automatic pulse_start(input logic [3:0] m);
    start = m;
    @(negedge clk);
    start = 4'd0;
  endtask

  task automatic wait_req(output logic ok);
    int n;
    n = 0;
    while (!req && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = req;
    if (!ok) chk("req_timeout", {63'd0, req}, 64'd1);
  endtask

  // Wait for a command, optionally hold off ack, compare against the
  // scoreboard, then ack it (optionally with a last for lch in the same cycle).
  task automatic accept(input int hold, input int lch, output logic [49:0] dout);
    logic        ok;
    logic        stable;
    logic [49:0] d0;
    cmd_t        e;
    dout = 50'd0;
    wait_req(ok);
    if (ok) begin
      d0 = data;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!req || data !== d0) stable = 1'b0;
      end
      if (hold > 0) chk("req_data_stable", {63'd0, stable}, 64'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_cmd", {14'd0, d0}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("cmd_ch", {62'd0, d0[49:48]}, 64'(e.ch));
        chk("cmd_addr", {32'd0, d0[47:16]}, {32'd0, e.addr});
        chk("cmd_len", {48'd0, d0[15:0]}, {48'd0, e.len});
      end
      dout = d0;
      ack = 1'b1;
      if (lch >= 0) begin
        last = 1'b1;
        last_ch = 2'(lch);
      end
      @(negedge clk);
      ack = 1'b0;
      last = 1'b0;
      chk("req_drop_after_ack", {63'd0, req}, 64'd0);
    end
  endtask

  task automatic send_last(input int ch, input logic exp_done);
    last = 1'b1;
    last_ch = 2'(ch);
    @(negedge clk);
    last = 1'b0;
    chk("done_after_last", {63'd0, done[ch]}, {63'd0, exp_done});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [49:0] d;
    logic        ok;

    rst = 1'b1; soft_rst = 4'd0; start = 4'd0; ack = 1'b0; last = 1'b0; last_ch = 2'd0;
    base = 128'd0; body = 64'd0; tail = 64'd0; num = 64'd0;
`ifdef TLK2711_TX_CMD_WRAP_EN
    ring = 32'hFFFF_FFF8;
`endif
    vecs[0] = '{0, 32'h0000_1000, 16'd870,   16'd100, 16'd2, 3, 32'h0000_16D0, 16'd104};
    vecs[1] = '{0, 32'h0000_2000, 16'd64,    16'd0,   16'd1, 1, 32'h0000_2000, 16'd64};
    vecs[2] = '{1, 32'h0000_3004, 16'd5,     16'd9,   16'd0, 1, 32'h0000_3004, 16'd16};
    vecs[3] = '{3, 32'hFFFF_FFF0, 16'd16,    16'd1,   16'd2, 3, 32'h0000_0010, 16'd8};
    vecs[4] = '{2, 32'h0000_4000, 16'hFFFF,  16'd0,   16'd1, 1, 32'h0000_4000, 16'd0};
    vecs[5] = '{1, 32'h0000_5000, 16'd8,     16'd0,   16'd0, 0, 32'h0000_0000, 16'd0};

    repeat (3) @(negedge clk);
    chk("reset_req", {63'd0, req}, 64'd0);
    chk("reset_data", {14'd0, data}, 64'd0);
    chk("reset_busy", {60'd0, busy}, 64'd0);
    chk("reset_done", {60'd0, done}, 64'd0);
    chk("reset_err", {63'd0, err}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // All four channels started together: granted 0,1,2,3; first ack held off.
    for (int c = 0; c < 4; c++) begin
      cfg(c, 32'h0001_0000 + 32'(c) * 32'h100, 16'd8, 16'd0, 16'd1);
      push_xfer(c, 32'h0001_0000 + 32'(c) * 32'h100, 16'd8, 16'd0, 16'd1);
    end
    pulse_start(4'hF);
    chk("busy_after_start", {60'd0, busy}, 64'hF);
    accept(5, -1, d);
    accept(0, 0, d);
    chk("ack_and_last_same_cycle", {63'd0, done[0]}, 64'd1);
    accept(0, -1, d);
    accept(0, -1, d);
    send_last(1, 1'b1);
    send_last(2, 1'b1);
    send_last(3, 1'b1);

    // Single-channel transfer vectors.
    for (int v = 0; v < 6; v++) begin
      cfg(vecs[v].ch, vecs[v].base, vecs[v].body, vecs[v].tail, vecs[v].num);
      push_xfer(vecs[v].ch, vecs[v].base, vecs[v].body, vecs[v].tail, vecs[v].num);
      pulse_start(4'(1 << vecs[v].ch));
      if (vecs[v].exp_n == 0) begin
        chk("empty_xfer_done", {63'd0, done[vecs[v].ch]}, 64'd1);
        chk("empty_xfer_idle", {63'd0, busy[vecs[v].ch]}, 64'd0);
      end else begin
        for (int i = 0; i < vecs[v].exp_n; i++) begin
          accept(0, -1, d);
          if (i == vecs[v].exp_n - 1) begin
            chk("vec_last_addr", {32'd0, d[47:16]}, {32'd0, vecs[v].exp_last_addr});
            chk("vec_last_len", {48'd0, d[15:0]}, {48'd0, vecs[v].exp_last_len});
          end
          send_last(vecs[v].ch, (i == vecs[v].exp_n - 1));
        end
        chk("vec_idle_after", {63'd0, busy[vecs[v].ch]}, 64'd0);
      end
      chk("vec_queue_empty", 64'(exp_q.size()), 64'd0);
    end

    // Abort while requesting: pending req withdrawn, channel idle.
    cfg(2, 32'h0000_6800, 16'd8, 16'd0, 16'd1);
    pulse_start(4'b0100);
    wait_req(ok);
    soft_rst = 4'b0100;
    @(negedge clk);
    soft_rst = 4'd0;
    chk("withdraw_req", {63'd0, req}, 64'd0);
    chk("withdraw_idle", {63'd0, busy[2]}, 64'd0);
    repeat (4) @(negedge clk);
    chk("withdraw_no_reissue", {63'd0, req}, 64'd0);

    // Abort ch1 in WAIT while ch2 starts: ch1 drains silently, ch2 unaffected.
    cfg(1, 32'h0000_6000, 16'd8, 16'd0, 16'd3);
    push_cmd(1, 32'h0000_6000, 16'd8);
    pulse_start(4'b0010);
    accept(0, -1, d);
    cfg(2, 32'h0000_7000, 16'd16, 16'd0, 16'd1);
    push_cmd(2, 32'h0000_7000, 16'd16);
    soft_rst = 4'b0010;
    start = 4'b0100;
    @(negedge clk);
    soft_rst = 4'd0;
    start = 4'd0;
    chk("drain_busy", {63'd0, busy[1]}, 64'd1);
    accept(0, -1, d);
    send_last(1, 1'b0);
    chk("drain_no_err", {63'd0, err}, 64'd0);
    chk("drain_idle", {63'd0, busy[1]}, 64'd0);
    send_last(2, 1'b1);
    repeat (8) @(negedge clk);
    chk("no_more_ch1_cmds", {63'd0, req}, 64'd0);

    // Stray last on idle ch2.
    last = 1'b1;
    last_ch = 2'd2;
    @(negedge clk);
    last = 1'b0;
    chk("stray_last_err", {63'd0, err}, 64'd1);
    chk("stray_last_idle", {63'd0, busy[2]}, 64'd0);
    @(negedge clk);
    chk("err_is_pulse", {63'd0, err}, 64'd0);

    // Start on busy ch0 is ignored: the original config is what gets issued.
    cfg(0, 32'h0000_8000, 16'd8, 16'd0, 16'd1);
    push_cmd(0, 32'h0000_8000, 16'd8);
    pulse_start(4'b0001);
    cfg(0, 32'h0000_9000, 16'd32, 16'd0, 16'd2);
    pulse_start(4'b0001);
    chk("busy_start_err", {63'd0, err}, 64'd1);
    accept(0, -1, d);
    send_last(0, 1'b1);

    // Start with zero body length is rejected.
    cfg(3, 32'h0000_A000, 16'd0, 16'd8, 16'd1);
    pulse_start(4'b1000);
    chk("zero_body_err", {63'd0, err}, 64'd1);
    chk("zero_body_idle", {63'd0, busy[3]}, 64'd0);

    // Reset mid-transfer; the late last is then flagged.
    cfg(0, 32'h0000_B000, 16'd8, 16'd0, 16'd1);
    push_cmd(0, 32'h0000_B000, 16'd8);
    pulse_start(4'b0001);
    accept(0, -1, d);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_abort_idle", {60'd0, busy}, 64'd0);
    last = 1'b1;
    last_ch = 2'd0;
    @(negedge clk);
    last = 1'b0;
    chk("late_last_err", {63'd0, err}, 64'd1);

`ifdef TLK2711_TX_CMD_WRAP_EN
    // Ring addressing: offsets 0x000, 0x400, 0x000 from base.
    ring = 32'h0000_0800;
    cfg(0, 32'h0001_0000, 16'h0400, 16'd0, 16'd3);
    push_cmd(0, 32'h0001_0000, 16'h0400);
    push_cmd(0, 32'h0001_0400, 16'h0400);
    push_cmd(0, 32'h0001_0000, 16'h0400);
    pulse_start(4'b0001);
    for (int i = 0; i < 3; i++) begin
      accept(0, -1, d);
      send_last(0, (i == 2));
    end
`endif

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
